// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_arbiter_nport_if.sv
// Client request/response and shared memory port bundle for the N-port arbiter.
interface mem_arbiter_nport_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [NUM_PORTS-1:0]            req_cs_i;
  logic [NUM_PORTS-1:0]            req_we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata_i;
  logic [DATA_WIDTH-1:0]           rsp_rdata_o;
  logic [NUM_PORTS-1:0]            rsp_rvalid_o;
  logic [NUM_PORTS-1:0]            rsp_err_o;
  logic [ADDR_WIDTH-1:0]           addr_o;
  logic [DATA_WIDTH-1:0]           wdata_o;
  logic                            we_o;
  logic                            cs_o;
  logic [DATA_WIDTH-1:0]           rdata_i;
  logic                            rvalid_i;
  logic                            handshaked_i;

  // Arbiter side.
  modport slave (
    input  req_cs_i, req_we_i, req_addr_i, req_wdata_i, rdata_i, rvalid_i, handshaked_i,
    output rsp_rdata_o, rsp_rvalid_o, rsp_err_o, addr_o, wdata_o, we_o, cs_o
  );

  // Clients plus memory, as seen from outside the arbiter.
  modport master (
    output req_cs_i, req_we_i, req_addr_i, req_wdata_i, rdata_i, rvalid_i, handshaked_i,
    input  rsp_rdata_o, rsp_rvalid_o, rsp_err_o, addr_o, wdata_o, we_o, cs_o
  );
endinterface

// File: rtl/arb_rr_picker.sv
// Combinational picker: rotating priority from ptr+1, or fixed priority with index 0 highest.
module arb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          fixed,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);
  logic [IW-1:0] w_idx;

  // Loops run from lowest priority upward so the last hit is the winner.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    w_idx     = '0;
    if (fixed) begin
      for (int i = N-1; i >= 0; i--)
        if (req[i]) gnt_idx = IW'(i);
    end else begin
      for (int i = N; i >= 1; i--) begin
        w_idx = IW'((int'(ptr) + i) % N);
        if (req[w_idx]) gnt_idx = w_idx;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter_nport.sv
// N-port arbiter: one outstanding line request at a time onto a shared memory port, with watchdog.
module mem_arbiter_nport
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_arbiter_nport_if.slave bus
);
  localparam int            IW       = clog2_min1(NUM_PORTS);
  localparam int            TW       = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] PTR_RST  = IW'(NUM_PORTS - 1);

  state_e                r_state, w_next;
  logic [IW-1:0]         r_gnt, r_ptr, w_pick;
  logic                  w_pick_vld;
  logic                  r_we, r_err, w_lat_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_lat_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata, w_lat_wdata;
  logic [TW-1:0]         r_timer;
  logic                  w_tmo, w_abort, w_cap;
  logic [NUM_PORTS-1:0]  w_onehot;

  arb_rr_picker #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .req      (bus.req_cs_i),
    .ptr      (r_ptr),
    .fixed    (FIXED_PRIO == ARB_FIXED),
    .gnt_idx  (w_pick),
    .gnt_valid(w_pick_vld)
  );

  // Mux out the winner's request fields with constant slices.
  always_comb begin
    w_lat_we    = 1'b0;
    w_lat_addr  = '0;
    w_lat_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_pick == IW'(p)) begin
        w_lat_we    = bus.req_we_i[p];
        w_lat_addr  = bus.req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_lat_wdata = bus.req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // >= keeps an abort reachable if the handshake lands on the last ISSUE cycle.
  assign w_tmo = TMO_EN && (r_timer >= TMO_LAST);

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    w_cap   = 1'b0;
    case (r_state)
      IDLE:  if (w_pick_vld) w_next = ISSUE;
      ISSUE: begin
        if (bus.handshaked_i) begin
          w_cap  = bus.rvalid_i;
          w_next = bus.rvalid_i ? DONE : WAIT;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = DONE;
        end
      end
      WAIT: begin
        if (bus.rvalid_i) begin
          w_cap  = 1'b1;
          w_next = DONE;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= PTR_RST;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_pick_vld) begin
          r_gnt   <= w_pick;
          r_ptr   <= w_pick;
          r_we    <= w_lat_we;
          r_addr  <= w_lat_addr;
          r_wdata <= w_lat_wdata;
          r_err   <= 1'b0;
          r_timer <= '0;
        end
        ISSUE, WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (w_abort) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else if (w_cap) begin
            r_rdata <= bus.rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_onehot         = NUM_PORTS'(1) << r_gnt;
  assign bus.cs_o         = (r_state == ISSUE);
  assign bus.we_o         = r_we & (r_state == ISSUE);
  assign bus.addr_o       = r_addr;
  assign bus.wdata_o      = r_wdata;
  assign bus.rsp_rdata_o  = r_rdata;
  assign bus.rsp_rvalid_o = (r_state == DONE) ? w_onehot : '0;
  assign bus.rsp_err_o    = (r_state == DONE && r_err) ? w_onehot : '0;
endmodule
